// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the configurable UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - rx synchronizer, start-edge detect, bit timer and 3-sample vote
module uart_bit_sampler #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic cnt_clr,
  output logic start_edge,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_wrap
);
  import uart_pkg::*;

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic          sync1, rx_s, rx_d;
  logic          samp0, samp1;
  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      bit_cnt <= '0;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      if (cnt_clr || bit_wrap) bit_cnt <= '0;
      else                     bit_cnt <= bit_cnt + CW'(1);
      if (bit_cnt == CW'(HALF - 1)) samp0 <= rx_s;
      if (bit_cnt == CW'(HALF))     samp1 <= rx_s;
    end
  end

  // third sample is taken live so the vote is ready at HALF+1
  assign start_edge = !rx_s && rx_d;
  assign bit_wrap   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_valid  = (bit_cnt == CW'(HALF + 1));
  assign bit_val    = maj3(samp0, samp1, rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with parity/framing/break/overrun flags
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  import uart_pkg::*;

  state_t               state, state_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n, ferr, ferr_n;
  logic                 done, fe_now, pe_now, bk_now, par_x;
  logic                 start_edge, bit_valid, bit_val, bit_wrap, cnt_clr;

  // counter is held at zero while idle so the edge cycle is bit_cnt = 0
  assign cnt_clr = (state == ST_IDLE) && !start_edge;

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .cnt_clr    (cnt_clr),
    .start_edge (start_edge),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .bit_wrap   (bit_wrap)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    ferr_n    = ferr;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start_edge) begin
        state_n   = ST_START;
        idx_n     = '0;
        ferr_n    = 1'b0;
        par_bit_n = 1'b0;
      end
      ST_START: begin
        if (bit_valid && bit_val) state_n = ST_IDLE;
        else if (bit_wrap)        state_n = ST_DATA;
      end
      ST_DATA: begin
        if (bit_valid) shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
        if (bit_wrap) begin
          if (idx == 4'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_valid) par_bit_n = bit_val;
        if (bit_wrap)  state_n   = ST_STOP;
      end
      ST_STOP: begin
        // last stop bit completes at its vote so a back-to-back start is not missed
        if (bit_valid) begin
          if (!bit_val) ferr_n = 1'b1;
          if (idx == 4'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_n = ST_IDLE;
          end
        end else if (bit_wrap) begin
          idx_n = idx + 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign par_x  = (^shreg) ^ par_bit;
  assign pe_now = (PARITY == PAR_ODD) ? !par_x : (PARITY == PAR_EVEN) ? par_x : 1'b0;
  assign fe_now = ferr | !bit_val;
  assign bk_now = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && fe_now;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr       <= 1'b0;
      data       <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      ferr    <= ferr_n;
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          data       <= shreg;
          parity_err <= pe_now;
          frame_err  <= fe_now;
          break_det  <= bk_now;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1, 8E1, 8O1, 7N2 builds)
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] rx, rdy, vld, pe, fe, bk, ovr;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [8:0] dat [4];

  always #5 clk = ~clk;

  always_comb begin
    dat[0] = {1'b0, d0};
    dat[1] = {1'b0, d1};
    dat[2] = {1'b0, d2};
    dat[3] = {2'b00, d3};
  end

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .rx(rx[0]), .data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]), .overrun(ovr[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .rx(rx[1]), .data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]), .overrun(ovr[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .rx(rx[2]), .data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]), .overrun(ovr[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .rx(rx[3]), .data(d3), .rx_valid(vld[3]), .rx_ready(rdy[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bk[3]), .overrun(ovr[3]));

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } word_t;

  typedef struct {
    int         u;
    logic [8:0] w;
    bit         pflip;
    logic [1:0] slow;
    int         gk;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
    logic       ebk;
  } vec_t;

  int nb [4] = '{8, 8, 8, 7};
  int pm [4] = '{0, 2, 1, 0};
  int ns [4] = '{1, 1, 1, 2};

  word_t      got [4][$];
  word_t      mon_w;
  int         cyc = 0;
  int         rise_cyc [4];
  int         ovr_cnt [4];
  bit         ovr_wide [4];
  logic [3:0] vld_prev = '0;
  logic [3:0] ovr_prev = '0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (vld[u] === 1'b1 && rdy[u] === 1'b1) begin
        mon_w.data = dat[u];
        mon_w.pe   = pe[u];
        mon_w.fe   = fe[u];
        mon_w.bk   = bk[u];
        got[u].push_back(mon_w);
      end
      if (vld[u] === 1'b1 && vld_prev[u] !== 1'b1) rise_cyc[u] = cyc;
      if (ovr[u] === 1'b1 && ovr_prev[u] !== 1'b1) ovr_cnt[u]++;
      if (ovr[u] === 1'b1 && ovr_prev[u] === 1'b1) ovr_wide[u] = 1'b1;
    end
    vld_prev = vld;
    ovr_prev = ovr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // reference: the word a receiver of build u should report for the bits on the wire
  function automatic word_t model(input int u, input logic [8:0] word, input logic pbit,
                                  input logic [1:0] stops);
    word_t w;
    int    ones;
    w.data = word & 9'((1 << nb[u]) - 1);
    ones   = $countones(w.data) + int'(pbit);
    w.pe   = (pm[u] == 1) ? (ones % 2 == 0) : (pm[u] == 2) ? (ones % 2 == 1) : 1'b0;
    w.fe   = (stops[0] == 1'b0) || (ns[u] == 2 && stops[1] == 1'b0);
    w.bk   = (w.data == 9'd0) && (pm[u] == 0 || pbit == 1'b0) && w.fe;
    return w;
  endfunction

  task automatic send_frame(input int u, input logic [8:0] word, input bit par_flip,
                            input logic [1:0] stop_low, input int glitch_k, input int gap,
                            output word_t exp, output int c0);
    logic       bits [$];
    logic       pbit;
    logic [1:0] stops;
    int         ones;
    c0 = cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < nb[u]; i++) bits.push_back(word[i]);
    ones = $countones(word & 9'((1 << nb[u]) - 1));
    pbit = ((pm[u] == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ par_flip;
    if (pm[u] != 0) bits.push_back(pbit);
    stops = ~stop_low;
    for (int i = 0; i < ns[u]; i++) bits.push_back(stops[i]);
    exp = model(u, word, pbit, stops);
    for (int k = 0; k < bits.size(); k++) begin
      for (int j = 0; j < CPB; j++) begin
        rx[u] = (k == glitch_k && j == HALF) ? ~bits[k] : bits[k];
        @(posedge clk);
        #2;
      end
    end
    rx[u] = 1'b1;
    tick(gap);
  endtask

  task automatic chk_word(input string nm, input int u, input logic [8:0] ed,
                          input logic epe, input logic efe, input logic ebk);
    word_t w;
    chk({nm, " count"}, got[u].size(), 1);
    if (got[u].size() > 0) begin
      w = got[u].pop_front();
      chk({nm, " data"}, w.data, ed);
      chk({nm, " parity_err"}, w.pe, epe);
      chk({nm, " frame_err"}, w.fe, efe);
      chk({nm, " break_det"}, w.bk, ebk);
    end
    got[u].delete();
  endtask

  initial begin
    vec_t       vt [7];
    word_t      e;
    int         c0;
    logic [9:0] fr;
    logic [8:0] rw;
    bit         rpf;
    logic [1:0] rsl;

    vt[0] = '{0, 9'h0A5, 1'b0, 2'b00, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, 9'h03C, 1'b1, 2'b00, -1, 9'h03C, 1'b1, 1'b0, 1'b0};
    vt[2] = '{2, 9'h03C, 1'b0, 2'b00, -1, 9'h03C, 1'b0, 1'b0, 1'b0};
    vt[3] = '{3, 9'h055, 1'b0, 2'b10, -1, 9'h055, 1'b0, 1'b1, 1'b0};
    vt[4] = '{0, 9'h05A, 1'b0, 2'b00,  3, 9'h05A, 1'b0, 1'b0, 1'b0};
    vt[5] = '{2, 9'h000, 1'b1, 2'b01, -1, 9'h000, 1'b1, 1'b1, 1'b1};
    vt[6] = '{1, 9'h0FF, 1'b0, 2'b00, -1, 9'h0FF, 1'b0, 1'b0, 1'b0};

    for (int u = 0; u < 4; u++) begin
      ovr_cnt[u]  = 0;
      ovr_wide[u] = 1'b0;
      rise_cyc[u] = 0;
    end
    rx      = '1;
    rdy     = '1;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    chk("reset rx_valid", 32'(vld), 0);
    chk("reset flags", {20'd0, pe, fe, bk}, 0);
    chk("reset overrun", 32'(ovr), 0);
    chk("reset data", {dat[0][7:0], dat[1][7:0], dat[2][7:0], 1'b0, dat[3][6:0]}, 0);
    tick(4);

    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].u, vt[i].w, vt[i].pflip, vt[i].slow, vt[i].gk, 8, e, c0);
      chk_word($sformatf("vec%0d", i), vt[i].u, vt[i].ed, vt[i].epe, vt[i].efe, vt[i].ebk);
      if (i == 0) chk("8N1 latency", 32'(rise_cyc[0] - c0), 32'(2 + (1 + 8 + 0 + 1 - 1) * CPB + HALF + 2));
    end

    for (int n = 0; n < 30; n++) begin
      rw  = 9'($urandom_range(0, 255));
      rpf = ($urandom_range(0, 3) == 0);
      rsl = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      send_frame(1, rw, rpf, rsl, -1, 20, e, c0);
      chk_word($sformatf("rand%0d", n), 1, e.data, e.pe, e.fe, e.bk);
    end

    // back-to-back frames while the consumer stalls
    rdy[0]     = 1'b0;
    ovr_cnt[0] = 0;
    send_frame(0, 9'h001, 1'b0, 2'b00, -1, 0, e, c0);
    send_frame(0, 9'h002, 1'b0, 2'b00, -1, 20, e, c0);
    chk("b2b held valid", 32'(vld[0]), 1);
    chk("b2b held data", 32'(dat[0]), 32'h01);
    chk("b2b overrun count", 32'(ovr_cnt[0]), 1);
    chk("b2b overrun width", 32'(ovr_wide[0]), 0);
    rdy[0] = 1'b1;
    tick(2);
    chk("b2b drop valid", 32'(vld[0]), 0);
    chk_word("b2b accept", 0, 9'h001, 1'b0, 1'b0, 1'b0);

    // 4-cycle low glitch on an idle line
    rx[0] = 1'b0;
    tick(4);
    rx[0] = 1'b1;
    tick(200);
    chk("glitch count", got[0].size(), 0);
    chk("glitch valid", 32'(vld[0]), 0);

    // line held low for three 7N2 frame times
    got[3].delete();
    rx[3] = 1'b0;
    tick(3 * 10 * CPB);
    chk("break hold count", got[3].size(), 1);
    rx[3] = 1'b1;
    tick(100);
    chk_word("break", 3, 9'h000, 1'b0, 1'b1, 1'b1);

    // reset pulse in the middle of DATA with a word still held
    rdy[0] = 1'b0;
    send_frame(0, 9'h03C, 1'b0, 2'b00, -1, 4, e, c0);
    chk("pre-reset held", 32'(vld[0]), 1);
    fr = {1'b1, 8'hF0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        rx[0]   = fr[k];
        reset_n = !(k == 5 && j == 3);
        if (k == 5 && j == 4) begin
          chk("midreset valid", 32'(vld[0]), 0);
          chk("midreset data", 32'(dat[0]), 0);
          chk("midreset flags", {29'd0, pe[0], fe[0], bk[0]}, 0);
          chk("midreset overrun", 32'(ovr[0]), 0);
        end
        @(posedge clk);
        #2;
      end
    end
    reset_n = 1'b1;
    rx[0]   = 1'b1;
    tick(40);
    chk("postreset count", got[0].size(), 0);
    chk("postreset valid", 32'(vld[0]), 0);
    rdy[0] = 1'b1;
    send_frame(0, 9'h0C3, 1'b0, 2'b00, -1, 8, e, c0);
    chk_word("after reset", 0, 9'h0C3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
